// File: rtl/multi_edge_synchronizer.sv
// Multi-channel synchroniser with per-channel glitch filter and selectable edge pulse.
// Optional MULTI_EDGE_STICKY_EN adds clr_i/sticky_o per-channel sticky edge flags.
module multi_edge_synchronizer #(
  parameter int DLY         = 1,
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1,
  parameter int EDGE_MODE   = 0,
  parameter int RST_VAL     = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH_NUM-1:0] async_i,
  input  logic              en_i,
`ifdef MULTI_EDGE_STICKY_EN
  input  logic [CH_NUM-1:0] clr_i,
  output logic [CH_NUM-1:0] sticky_o,
`endif
  output logic [CH_NUM-1:0] level_o,
  output logic [CH_NUM-1:0] pulse_o
);

  localparam int              CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam int              EM      = (EDGE_MODE == 1 || EDGE_MODE == 2) ? EDGE_MODE : 0;
  localparam logic [CH_NUM-1:0] L_RST = {CH_NUM{(RST_VAL != 0)}};

  logic [CH_NUM-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0]  r_cnt  [CH_NUM];
  logic [CH_NUM-1:0] r_level;
  logic [CH_NUM-1:0] r_pulse;
  logic [CH_NUM-1:0] w_sync_q;
  logic [CH_NUM-1:0] w_edge_ok;
  logic              w_unused_dly;

  // DLY only matters in simulation; the synthesised logic has no use for it.
  assign w_unused_dly = (DLY >= 0);

  assign w_sync_q  = r_sync[SYNC_STAGES-1];
  assign w_edge_ok = (EM == 2) ? {CH_NUM{1'b1}} : (EM == 1) ? ~w_sync_q : w_sync_q;
  assign level_o   = r_level;
  assign pulse_o   = r_pulse;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= L_RST;
    end else begin
      r_sync[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int ch = 0; ch < CH_NUM; ch++) r_cnt[ch] <= '0;
      r_level <= L_RST;
      r_pulse <= '0;
    end else if (!en_i) begin
      for (int ch = 0; ch < CH_NUM; ch++) r_cnt[ch] <= '0;
      r_pulse <= '0;
    end else begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        r_pulse[ch] <= 1'b0;
        if (w_sync_q[ch] == r_level[ch]) begin
          r_cnt[ch] <= '0;
        end else if (r_cnt[ch] == CNT_MAX) begin
          r_level[ch] <= w_sync_q[ch];
          r_cnt[ch]   <= '0;
          // Back-to-back acceptance is only possible when unfiltered; keep pulses apart.
          r_pulse[ch] <= w_edge_ok[ch] & ~r_pulse[ch];
        end else begin
          r_cnt[ch] <= r_cnt[ch] + 1'b1;
        end
      end
    end
  end

`ifdef MULTI_EDGE_STICKY_EN
  logic [CH_NUM-1:0] r_sticky;

  assign sticky_o = r_sticky;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_sticky <= '0;
    else       r_sticky <= r_pulse | (r_sticky & ~clr_i);
  end
`endif

endmodule
